// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C arbiter slice: FSM states and the latched command.
package i2c_pkg;

  localparam int I2C_NB_W   = 6;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESP
  } i2c_state_t;

  typedef struct packed {
    logic                  rw;
    logic [I2C_NB_W-1:0]   nbyte;
    logic [I2C_ADDR_W-1:0] dev;
    logic [I2C_DATA_W-1:0] ptr;
  } i2c_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the port after the most recently granted one has priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (last) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  // last resets to 1 so that port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (reset)                      last <= 1'b1;
    else if (update && gnt != 2'b00) last <= gnt[1];
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master between two requesters: arbitrate, latch command, launch, track done, respond.
//   state  | meaning
//   IDLE   | wait for a request while the master reports done
//   ARB    | pick winner, latch its command, clear status
//   LAUNCH | m_go high until the master drops done (or launch timeout)
//   BUSY   | collect ack errors / read data until done rises
//   RESP   | one-cycle cmpl pulse to the granted port, release grant
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int LAUNCH_TO = 64,
  parameter int BUSY_TO   = 2**20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [NREQ*I2C_NB_W-1:0]   req_nbyte,
  input  logic [NREQ*I2C_ADDR_W-1:0] req_dev,
  input  logic [NREQ*I2C_DATA_W-1:0] req_ptr,
  input  logic [NREQ*I2C_DATA_W-1:0] req_dwr,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            cmpl,
  output logic [I2C_DATA_W-1:0]      rsp_drd,
  output logic                       rsp_ack_err,
  output logic                       rsp_to,
  output logic                       m_go,
  output logic                       m_rw,
  output logic [I2C_NB_W-1:0]        m_nbyte,
  output logic [I2C_ADDR_W-1:0]      m_dev,
  output logic [I2C_DATA_W-1:0]      m_ptr,
  output logic [I2C_DATA_W-1:0]      m_dwr,
  input  logic                       m_done,
  input  logic                       m_ack_e,
  input  logic [I2C_DATA_W-1:0]      m_drd
);

  localparam logic [20:0] LAUNCH_TC = 21'(LAUNCH_TO - 1);
  localparam logic [20:0] BUSY_TC   = 21'(BUSY_TO - 1);

  i2c_state_t            state;
  i2c_cmd_t              cmd, sel_cmd;
  logic [1:0]            win;
  logic [20:0]           launch_cnt, busy_cnt;
  logic [I2C_DATA_W-1:0] drd_prev;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (state == ST_ARB),
    .gnt    (win)
  );

  always_comb begin
    sel_cmd = '0;
    if (win[0]) begin
      sel_cmd.rw    = req_rw[0];
      sel_cmd.nbyte = req_nbyte[I2C_NB_W-1:0];
      sel_cmd.dev   = req_dev[I2C_ADDR_W-1:0];
      sel_cmd.ptr   = req_ptr[I2C_DATA_W-1:0];
    end else if (win[1]) begin
      sel_cmd.rw    = req_rw[1];
      sel_cmd.nbyte = req_nbyte[2*I2C_NB_W-1:I2C_NB_W];
      sel_cmd.dev   = req_dev[2*I2C_ADDR_W-1:I2C_ADDR_W];
      sel_cmd.ptr   = req_ptr[2*I2C_DATA_W-1:I2C_DATA_W];
    end
  end

  // write data streams live from the client that holds the grant
  always_comb begin
    m_dwr = '0;
    if (gnt[0])      m_dwr = req_dwr[I2C_DATA_W-1:0];
    else if (gnt[1]) m_dwr = req_dwr[2*I2C_DATA_W-1:I2C_DATA_W];
  end

  assign m_rw    = cmd.rw;
  assign m_nbyte = cmd.nbyte;
  assign m_dev   = cmd.dev;
  assign m_ptr   = cmd.ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      cmpl        <= '0;
      m_go        <= 1'b0;
      cmd         <= '0;
      rsp_drd     <= '0;
      rsp_ack_err <= 1'b0;
      rsp_to      <= 1'b0;
      launch_cnt  <= '0;
      busy_cnt    <= '0;
      drd_prev    <= '0;
    end else begin
      drd_prev <= m_drd;
      case (state)
        ST_IDLE: begin
          if (|req && m_done) state <= ST_ARB;
        end
        ST_ARB: begin
          if (win == 2'b00) begin
            state <= ST_IDLE;
          end else begin
            gnt         <= win;
            cmd         <= sel_cmd;
            rsp_ack_err <= 1'b0;
            rsp_to      <= 1'b0;
            if (sel_cmd.nbyte == '0) begin
              cmpl  <= win;
              state <= ST_RESP;
            end else begin
              m_go       <= 1'b1;
              launch_cnt <= '0;
              state      <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          if (!m_done) begin
            m_go     <= 1'b0;
            busy_cnt <= '0;
            state    <= ST_BUSY;
          end else if (launch_cnt == LAUNCH_TC) begin
            m_go   <= 1'b0;
            rsp_to <= 1'b1;
            cmpl   <= gnt;
            state  <= ST_RESP;
          end else begin
            launch_cnt <= launch_cnt + 21'd1;
          end
        end
        ST_BUSY: begin
          rsp_ack_err <= rsp_ack_err | m_ack_e;
          if (m_drd != '0 && m_drd != drd_prev) rsp_drd <= m_drd;
          // the master cannot be aborted, so a busy timeout only flags status
          if (busy_cnt == BUSY_TC) rsp_to   <= 1'b1;
          else                     busy_cnt <= busy_cnt + 21'd1;
          if (m_done) begin
            cmpl  <= gnt;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          cmpl  <= '0;
          gnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter and transaction sequencer that shares one `I2c` master between two requester ports. It latches the winning port's command, launches the master with a `go` strobe and tracks its `done` handshake through the transaction. It then returns completion, read data and error status to the granted port. It sits between the I2C master and the system-side clients, for example a sensor poller and a configuration loader.

## Interface
- `NREQ`, 2: number of requester ports; fixed at 2 for this revision.
- `LAUNCH_TO`, 64: cycles allowed for `done` to fall after `go` is asserted.
- `BUSY_TO`, 2**20: cycles allowed for `done` to rise again after it falls.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  2  per-port request level; held high until `cmpl` is seen.
- `req_rw`  in  2  per-port read (1) or write (0).
- `req_nbyte`  in  12  per-port byte count, 6 bits per port; port p uses bits [6p+5:6p].
- `req_dev`  in  14  per-port 7-bit device address.
- `req_ptr`  in  16  per-port 8-bit register pointer.
- `req_dwr`  in  16  per-port write data, muxed live to the master.
- `gnt`  out  2  one-hot grant; high from ARB exit until RESP.
- `cmpl`  out  2  one-cycle completion pulse to the granted port.
- `rsp_drd`  out  8  last read byte from the master, captured each time `drd` changes while BUSY.
- `rsp_ack_err`  out  1  NACK seen during the transaction; valid with `cmpl`.
- `rsp_to`  out  1  timeout occurred; valid with `cmpl`.
- `m_go`, `m_rw`, `m_nbyte[5:0]`, `m_dev[6:0]`, `m_ptr[7:0]`, `m_dwr[7:0]`  out  master command bus.
- `m_done`, `m_ack_e`, `m_drd[7:0]`  in  master status bus.

## Operation
- States: IDLE, ARB, LAUNCH, BUSY, RESP.
- IDLE: if any `req` is high and `m_done`=1, go to ARB. Otherwise stay in IDLE.
- ARB (one cycle):
  - Pick a winner by round-robin. `last` is a 1-bit register holding the most recently granted port; the port after `last` has priority.
  - Set the winner's `gnt` bit and latch its rw, nbyte, dev and ptr into the command registers. Update `last`.
  - Clear `rsp_ack_err` and `rsp_to`.
  - If the latched nbyte is 0, go directly to RESP with no launch.
- LAUNCH:
  - `m_go` is 1.
  - When `m_done` falls to 0, drop `m_go` and go to BUSY.
  - If `LAUNCH_TO` cycles pass without that, drop `m_go`, set `rsp_to` and go to RESP.
- BUSY:
  - OR `m_ack_e` into `rsp_ack_err` every cycle.
  - Update `rsp_drd` from `m_drd` whenever `m_drd` is nonzero and differs from the previous sample.
  - When `m_done` rises to 1, go to RESP.
  - After `BUSY_TO` cycles, set `rsp_to` but remain in BUSY; the master cannot be aborted.
- RESP: pulse `cmpl` for the granted port, clear `gnt`, go to IDLE.
- `m_dwr` = `req_dwr` of the granted port, combinationally; it is 0 when there is no grant. The client streams its bytes on this bus.
- `m_rw`, `m_nbyte`, `m_dev`, `m_ptr` come from the latched registers and are stable from ARB until RESP.

## Timing
- Reset values: `gnt`=0, `cmpl`=0, `m_go`=0, all `m_*` command outputs = 0, `rsp_*`=0, `last`=1 (port 0 wins first), state=IDLE.
- Fastest path from `req` rising to `m_go` rising is 2 cycles: IDLE→ARB, then ARB→LAUNCH.
- `cmpl` occurs 1 cycle after `m_done` rises.
- The zero-byte path gives `cmpl` 2 cycles after `req` rises.
- A requester must drop `req` within 1 cycle of `cmpl`. If it is still high in IDLE, it is a new request.
- Simultaneous requests: the port after `last` wins and the other waits. Two back-to-back requests alternate between ports.
- A request arriving during a transaction is held off until IDLE; arbitration happens only in ARB.
- `m_done`=0 while in IDLE (an external master is busy): no arbitration takes place.
- Reset mid-transaction: all state returns to reset values immediately and `m_go` drops. The master is reset by the same `reset`.
- Both timeout counters are 21 bits, saturating, and cleared on entry to LAUNCH and to BUSY respectively.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum;
  - constants `I2C_NB_W`=6, `I2C_ADDR_W`=7, `I2C_DATA_W`=8;
  - a command struct {rw, nbyte, dev, ptr}.
- One natural sub-module: `rr_arb2`, a 2-way round-robin grant with a `last` register and an `update` enable. Everything else lives in `i2c_arbiter`.

## Test plan
- Single write: port 0 requests rw=0, nbyte=2, dev=0x48, ptr=0x01.
  - `gnt`=01 and `m_go` high 2 cycles after `req`.
  - A master model drops `done` 3 cycles later; `m_go` falls in the same cycle.
  - After `done` rises, `cmpl[0]` pulses once and `rsp_ack_err`=0.
- Contention: both ports request in the same cycle after reset. Grant order is 0, then 1, then 0 on repeated requests. `m_dev` follows the granted port.
- NACK: the model pulses `m_ack_e` for 1 cycle mid-transaction. `cmpl` arrives with `rsp_ack_err`=1; the next transaction starts with it cleared.
- Launch timeout: the model never drops `done`. `m_go` is high for exactly 64 cycles, then `cmpl` arrives with `rsp_to`=1.
- Read plus zero-byte:
  - Port 1 requests rw=1, nbyte=1; the model drives `drd`=0xA5. `rsp_drd`=0xA5 at `cmpl`.
  - A request with nbyte=0 gives `cmpl` and `m_go` never asserts.
- Reset mid-BUSY: assert `reset` for 1 cycle. All outputs return to 0, state is IDLE, and the next simultaneous request grants port 0.
